// File: rtl/pixbuf_pkg.sv
// ----------------------------------------------------------------------------
// pixbuf_pkg
// Shared definitions for the pixel frame buffer:
//   PIXBUF_N_PIX_DEF  - default number of pixels per frame
//   PIXBUF_DATA_W_DEF - default Q15 pixel width
//   pixbuf_state_t    - control FSM states
//   pixbuf_err_t      - latched frame error codes
// ----------------------------------------------------------------------------
package pixbuf_pkg;

   localparam int PIXBUF_N_PIX_DEF  = 784;
   localparam int PIXBUF_DATA_W_DEF = 16;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_FILL  = 3'd2,
      S_READY = 3'd3,
      S_ERROR = 3'd4
   } pixbuf_state_t;

   typedef enum logic [1:0] {
      ERR_NONE   = 2'd0,
      ERR_SHORT  = 2'd1,
      ERR_LONG   = 2'd2,
      ERR_ORPHAN = 2'd3
   } pixbuf_err_t;

endpackage

// File: rtl/pixbuf_ram.sv
// ----------------------------------------------------------------------------
// pixbuf_ram
// Frame storage: one synchronous write port and one registered read port.
// Ports:
//   clk      - clock
//   we       - write enable
//   wr_addr  - write index
//   wr_data  - write data
//   re       - read enable; rd_q updates on the next rising edge
//   rd_addr  - read index (must be < DEPTH when re is high)
//   rd_q     - registered read data, holds while re is low
// ----------------------------------------------------------------------------
module pixbuf_ram #(
   parameter int DEPTH = 784,
   parameter int WIDTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             re,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_q
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: the array and its read register have no reset so the storage maps
   // onto block RAM; frame contents survive a reset of the control logic.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
      if (re) begin
         rd_q <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/pixel_buffer.sv
// ----------------------------------------------------------------------------
// pixel_buffer
// Captures one frame of N_PIX Q15 pixels from a streaming source, holds it
// for a consumer to read randomly, and latches framing errors.
//
// Optional feature macro: PIXBUF_CHECKSUM_EN adds a 32-bit signed running
// sum of the sign-extended pixels written in the current frame.
//
// Ports:
//   clk, reset     - clock; asynchronous active-high reset
//   load           - request capture of one frame (honoured in IDLE only)
//   src_start      - one-cycle start pulse to the pixel source
//   in_pixel       - pixel from the source
//   in_valid       - in_pixel valid this cycle
//   in_done        - last pixel marker, qualified by in_valid
//   busy           - frame request/fill in progress
//   pix_count      - pixels written in the current frame
//   frame_ready    - a complete frame is held
//   release_frame  - consumer is finished with the frame
//   rd_en, rd_addr - read request and index
//   rd_data        - read data (0 when not valid or index out of range)
//   rd_valid       - rd_data valid, one cycle after rd_en in READY
//   err, err_code  - latched error flag and code (SHORT/LONG/ORPHAN_DONE)
//   clear_err      - acknowledge the error
//   checksum       - (PIXBUF_CHECKSUM_EN only) running signed pixel sum
// ----------------------------------------------------------------------------
module pixel_buffer
   import pixbuf_pkg::*;
#(
   parameter int N_PIX  = PIXBUF_N_PIX_DEF,
   parameter int DATA_W = PIXBUF_DATA_W_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       load,
   output logic                       src_start,
   input  logic [DATA_W-1:0]          in_pixel,
   input  logic                       in_valid,
   input  logic                       in_done,
   output logic                       busy,
   output logic [$clog2(N_PIX+1)-1:0] pix_count,
   output logic                       frame_ready,
   input  logic                       release_frame,
   input  logic                       rd_en,
   input  logic [$clog2(N_PIX)-1:0]   rd_addr,
   output logic [DATA_W-1:0]          rd_data,
   output logic                       rd_valid,
   output logic                       err,
   output logic [1:0]                 err_code,
   input  logic                       clear_err
`ifdef PIXBUF_CHECKSUM_EN
   ,
   output logic [31:0]                checksum
`endif
);

   localparam int CW = $clog2(N_PIX + 1);
   localparam int AW = $clog2(N_PIX);

   pixbuf_state_t     state;
   pixbuf_err_t       err_code_q;
   logic              rd_hit;
   logic              rd_in_range;
   logic              rd_fire;
   logic              wr_en;
   logic              frame_full;
   logic [DATA_W-1:0] ram_q;

   assign err_code = err_code_q;

   // A full frame already written: any further valid is an overflow and must
   // not touch memory (its index would be out of range anyway).
   assign frame_full  = (pix_count == CW'(N_PIX));
   assign wr_en       = (state == S_FILL) && in_valid && !frame_full;

   // Compare at integer width so the check stays correct when N_PIX is a
   // power of two and rd_addr cannot represent N_PIX itself.
   assign rd_in_range = (int'(rd_addr) < N_PIX);
   assign rd_fire     = rd_en && (state == S_READY) && rd_in_range;

   // The RAM read register is not reset, so out-of-range, out-of-state and
   // post-reset reads are forced to zero here.
   assign rd_data     = rd_hit ? ram_q : '0;

`ifdef PIXBUF_CHECKSUM_EN
   logic [31:0] pix_sext;
   assign pix_sext = 32'(signed'(in_pixel));
`endif

   pixbuf_ram #(
      .DEPTH (N_PIX),
      .WIDTH (DATA_W),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .we      (wr_en),
      .wr_addr (pix_count[AW-1:0]),
      .wr_data (in_pixel),
      .re      (rd_fire),
      .rd_addr (rd_addr),
      .rd_q    (ram_q)
   );

   // NOTE: all state and registered outputs update with non-blocking
   // assignments so every reader sees the pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         src_start   <= 1'b0;
         busy        <= 1'b0;
         pix_count   <= '0;
         frame_ready <= 1'b0;
         rd_valid    <= 1'b0;
         rd_hit      <= 1'b0;
         err         <= 1'b0;
         err_code_q  <= ERR_NONE;
`ifdef PIXBUF_CHECKSUM_EN
         checksum    <= '0;
`endif
      end else begin
         // Read side: the state of this cycle decides validity, so a read
         // issued together with release_frame still completes.
         rd_valid  <= rd_en && (state == S_READY);
         rd_hit    <= rd_fire;
         src_start <= 1'b0;

         case (state)
            S_IDLE: begin
               if (load) begin
                  state     <= S_REQ;
                  src_start <= 1'b1;
                  busy      <= 1'b1;
                  pix_count <= '0;
`ifdef PIXBUF_CHECKSUM_EN
                  checksum  <= '0;
`endif
               end
            end

            S_REQ: begin
               state <= S_FILL;
            end

            S_FILL: begin
               if (in_valid) begin
                  if (frame_full) begin
                     state      <= S_ERROR;
                     busy       <= 1'b0;
                     err        <= 1'b1;
                     err_code_q <= ERR_LONG;
                  end else begin
                     pix_count <= pix_count + CW'(1);
`ifdef PIXBUF_CHECKSUM_EN
                     checksum  <= checksum + pix_sext;
`endif
                     if (in_done) begin
                        busy <= 1'b0;
                        if (pix_count == CW'(N_PIX - 1)) begin
                           state       <= S_READY;
                           frame_ready <= 1'b1;
                        end else begin
                           state      <= S_ERROR;
                           err        <= 1'b1;
                           err_code_q <= ERR_SHORT;
                        end
                     end
                  end
               end else if (in_done) begin
                  state      <= S_ERROR;
                  busy       <= 1'b0;
                  err        <= 1'b1;
                  err_code_q <= ERR_ORPHAN;
               end
            end

            S_READY: begin
               if (release_frame) begin
                  state       <= S_IDLE;
                  frame_ready <= 1'b0;
               end
            end

            S_ERROR: begin
               if (clear_err) begin
                  state      <= S_IDLE;
                  err        <= 1'b0;
                  err_code_q <= ERR_NONE;
               end
            end

            default: begin
               state       <= S_IDLE;
               busy        <= 1'b0;
               frame_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_buffer.sv
// ----------------------------------------------------------------------------
// tb_pixel_buffer
// Self-checking bench for pixel_buffer: full frame capture and readback,
// short/long/orphan-done errors, reset mid-fill, out-of-range reads, reads in
// the wrong state and (with PIXBUF_CHECKSUM_EN) the running checksum.
// Read results go through a scoreboard queue filled when rd_en is driven.
// ----------------------------------------------------------------------------
module tb_pixel_buffer;
   import pixbuf_pkg::*;

   localparam int N_PIX  = 784;
   localparam int DATA_W = 16;
   localparam int CW     = $clog2(N_PIX + 1);
   localparam int AW     = $clog2(N_PIX);

   logic              clk = 1'b0;
   logic              reset;
   logic              load;
   logic              src_start;
   logic [DATA_W-1:0] in_pixel;
   logic              in_valid;
   logic              in_done;
   logic              busy;
   logic [CW-1:0]     pix_count;
   logic              frame_ready;
   logic              release_frame;
   logic              rd_en;
   logic [AW-1:0]     rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              err;
   logic [1:0]        err_code;
   logic              clear_err;
`ifdef PIXBUF_CHECKSUM_EN
   logic [31:0]       checksum;
`endif

   int n_cmp = 0;
   int n_err = 0;
   logic [DATA_W-1:0] exp_q [$];

   pixel_buffer #(
      .N_PIX  (N_PIX),
      .DATA_W (DATA_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .load          (load),
      .src_start     (src_start),
      .in_pixel      (in_pixel),
      .in_valid      (in_valid),
      .in_done       (in_done),
      .busy          (busy),
      .pix_count     (pix_count),
      .frame_ready   (frame_ready),
      .release_frame (release_frame),
      .rd_en         (rd_en),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .rd_valid      (rd_valid),
      .err           (err),
      .err_code      (err_code),
      .clear_err     (clear_err)
`ifdef PIXBUF_CHECKSUM_EN
      ,
      .checksum      (checksum)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard consumer: every rd_valid pops one expected read result.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rd_valid) begin
            if (exp_q.size() == 0) check("rd_unexpected", 32'(rd_valid), 32'd0);
            else                   check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic start_frame();
      load = 1'b1;
      tick();
      load = 1'b0;
      check("req_src_start", 32'(src_start), 32'd1);
      check("req_busy", 32'(busy), 32'd1);
      check("req_pix_count", 32'(pix_count), 32'd0);
`ifdef PIXBUF_CHECKSUM_EN
      check("req_checksum", checksum, 32'd0);
`endif
      tick();
      check("fill_src_start", 32'(src_start), 32'd0);
   endtask

   // Stream n pixels; value is base (constant) or base+index; in_done on index done_at.
   task automatic stream(input int n, input int done_at, input logic [DATA_W-1:0] base,
                         input bit const_val);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_pixel = const_val ? base : base + DATA_W'(i);
         in_done  = (i == done_at);
         tick();
      end
      in_valid = 1'b0;
      in_done  = 1'b0;
   endtask

   task automatic rd(input int addr, input logic [DATA_W-1:0] exp);
      rd_en   = 1'b1;
      rd_addr = AW'(addr);
      exp_q.push_back(exp);
      tick();
      rd_en = 1'b0;
      check("rd_valid_hi", 32'(rd_valid), 32'd1);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_src_start"}, 32'(src_start), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_pix_count"}, 32'(pix_count), 32'd0);
      check({tag, "_frame_ready"}, 32'(frame_ready), 32'd0);
      check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
      check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
      check({tag, "_err"}, 32'(err), 32'd0);
      check({tag, "_err_code"}, 32'(err_code), 32'd0);
      check({tag, "_state"}, 32'(dut.state), 32'(S_IDLE));
`ifdef PIXBUF_CHECKSUM_EN
      check({tag, "_checksum"}, checksum, 32'd0);
`endif
   endtask

   initial begin
      int pulses;
      reset = 1'b1; load = 1'b0; in_pixel = '0; in_valid = 1'b0; in_done = 1'b0;
      release_frame = 1'b0; rd_en = 1'b0; rd_addr = '0; clear_err = 1'b0;
      tick();
      check_zero_outputs("por");
      tick();
      reset = 1'b0;
      tick();

      // Full frame of pixel = index, readback and READY behaviour.
      start_frame();
      stream(N_PIX, N_PIX - 1, 16'h0000, 1'b0);
      check("f1_frame_ready", 32'(frame_ready), 32'd1);
      check("f1_pix_count", 32'(pix_count), 32'd784);
      check("f1_busy", 32'(busy), 32'd0);
      rd(5, 16'h0005);
      tick();
      check("rd_valid_lo", 32'(rd_valid), 32'd0);
      rd(783, 16'd783);
      rd(800, 16'h0000);
      check("rd_oob_data", 32'(rd_data), 32'd0);
      // Source activity and load in READY must be ignored.
      in_valid = 1'b1; in_done = 1'b1; in_pixel = 16'hBEEF; load = 1'b1;
      tick(); tick(); tick();
      in_valid = 1'b0; in_done = 1'b0; load = 1'b0;
      check("ready_hold", 32'(frame_ready), 32'd1);
      check("ready_no_start", 32'(src_start), 32'd0);
      check("ready_pix_count", 32'(pix_count), 32'd784);
      rd(0, 16'h0000);
      // Read issued together with release still completes.
      release_frame = 1'b1;
      rd(10, 16'd10);
      release_frame = 1'b0;
      check("rel_frame_ready", 32'(frame_ready), 32'd0);
      // Read outside READY.
      rd_en = 1'b1; rd_addr = AW'(5);
      tick();
      rd_en = 1'b0;
      check("idle_rd_valid", 32'(rd_valid), 32'd0);
      check("idle_rd_data", 32'(rd_data), 32'd0);

      // Short frame: done on pixel 700.
      start_frame();
      stream(701, 700, 16'h0000, 1'b0);
      check("short_err", 32'(err), 32'd1);
      check("short_code", 32'(err_code), 32'(ERR_SHORT));
      check("short_pix_count", 32'(pix_count), 32'd701);
      load = 1'b1;
      tick(); tick();
      load = 1'b0;
      check("short_hold_code", 32'(err_code), 32'(ERR_SHORT));
      check("short_no_start", 32'(src_start), 32'd0);
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      check("clr_err", 32'(err), 32'd0);
      check("clr_code", 32'(err_code), 32'd0);
      check("clr_state", 32'(dut.state), 32'(S_IDLE));

      // Long frame: 785 valids with no done.
      start_frame();
      stream(N_PIX, -1, 16'h1000, 1'b0);
      check("long_pre_count", 32'(pix_count), 32'd784);
      check("long_pre_busy", 32'(busy), 32'd1);
      check("long_pre_err", 32'(err), 32'd0);
      stream(1, -1, 16'h1000 + 16'd784, 1'b1);
      check("long_err", 32'(err), 32'd1);
      check("long_code", 32'(err_code), 32'(ERR_LONG));
      check("long_count", 32'(pix_count), 32'd784);
      check("long_mem783", 32'(dut.u_ram.mem[783]), 32'h1000 + 32'd783);
      clear_err = 1'b1; tick(); clear_err = 1'b0;

      // Orphan done: in_done without in_valid.
      start_frame();
      stream(10, -1, 16'h0000, 1'b0);
      in_done = 1'b1; tick(); in_done = 1'b0;
      check("orphan_code", 32'(err_code), 32'(ERR_ORPHAN));
      check("orphan_count", 32'(pix_count), 32'd10);
      clear_err = 1'b1; tick(); clear_err = 1'b0;

      // Reset at pixel 300 of a fill.
      start_frame();
      stream(300, -1, 16'h2000, 1'b0);
      in_valid = 1'b1; in_pixel = 16'h2000 + 16'd300;
      reset = 1'b1;
      #1;
      check_zero_outputs("midrst");
      in_valid = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      check("rst_mem_kept", 32'(dut.u_ram.mem[0]), 32'h2000);
      pulses = 0;
      load = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         load = 1'b0;
         if (src_start) pulses++;
      end
      check("rst_one_pulse", 32'(pulses), 32'd1);

      // Constant +1 frame (state already FILL), then constant -1 frame.
      stream(N_PIX, N_PIX - 1, 16'h0001, 1'b1);
      check("ones_ready", 32'(frame_ready), 32'd1);
`ifdef PIXBUF_CHECKSUM_EN
      check("ones_checksum", checksum, 32'd784);
      tick();
      check("ones_checksum_hold", checksum, 32'd784);
`endif
      rd(400, 16'h0001);
      release_frame = 1'b1; tick(); release_frame = 1'b0;
      start_frame();
      stream(N_PIX, N_PIX - 1, 16'hFFFF, 1'b1);
      check("neg_ready", 32'(frame_ready), 32'd1);
`ifdef PIXBUF_CHECKSUM_EN
      check("neg_checksum", checksum, 32'hFFFF_FCF0);
`endif
      rd(783, 16'hFFFF);
      tick(); tick();
      check("sb_drain", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
